// File: rtl/serial_fulladder.sv
// serial_fulladder: bit-serial, LSB-first adder of two WIDTH-bit operands
// plus carry-in. Each clock retires one bit using a full-add cell built from
// two b_halfadder instances and an OR of their carries. The carry lives in a
// flip-flop between bits. The result is published together with a one-cycle
// done pulse after WIDTH shift cycles.

// One-bit half adder cell: sum = a ^ b, carry = a & b.
module b_halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i;
  assign cout_o = a_i & b_i;

endmodule

module serial_fulladder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is one bit wider than needed to index WIDTH bits so it cannot wrap.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   s_sr_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  // Full-add cell wiring: first half adder combines the operand bits, the
  // second folds in the held carry; either half-adder carry propagates.
  logic               p_s;
  logic               g0_s;
  logic               s_d;
  logic               g1_s;
  logic               c_d;
  logic [WIDTH-1:0]   s_sr_d;
  logic               last_bit_s;

  b_halfadder u_ha_ab (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .sum_o  (p_s),
    .cout_o (g0_s)
  );

  b_halfadder u_ha_pc (
    .a_i    (p_s),
    .b_i    (c_q),
    .sum_o  (s_d),
    .cout_o (g1_s)
  );

  assign c_d        = g0_s | g1_s;
  assign s_sr_d     = {s_d, s_sr_q[WIDTH-1:1]};
  assign last_bit_s = (cnt_q == CNT_W'(WIDTH - 1));

  // Sequencer and datapath: accept in IDLE/DONE, retire one bit per SHIFT
  // cycle, publish the result on the last bit, and flag busy/done from
  // registers so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= {WIDTH{1'b0}};
      b_sr_q  <= {WIDTH{1'b0}};
      s_sr_q  <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            c_q     <= cin;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          s_sr_q <= s_sr_d;
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          c_q    <= c_d;
          cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_bit_s) begin
            sum_q   <= s_sr_d;
            cout_q  <= c_d;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
